// File: rtl/stats_reporter.sv
// rtl/stats_reporter.sv - snapshot instruction-mix counters and stream them as a 10-byte checksummed frame
module stats_reporter #(
    parameter int          W   = 11,     // counter width, 9..16
    parameter logic [7:0]  HDR = 8'hA5   // frame header byte
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i,
    input  logic [W-1:0] r,
    input  logic [W-1:0] j,
    input  logic [W-1:0] cnt_clk,
    input  logic         snap_req,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic [7:0]   drop_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [W-1:0]   snap_i_q, snap_i_d;
    logic [W-1:0]   snap_r_q, snap_r_d;
    logic [W-1:0]   snap_j_q, snap_j_d;
    logic [W-1:0]   snap_c_q, snap_c_d;
    logic           done_q, done_d;
    logic [7:0]     drop_q, drop_d;

    logic [15:0]    ext_i, ext_r, ext_j, ext_c;
    logic [7:0]     checksum;
    logic [7:0]     frame_byte;

    // Counters are zero-extended to 16 bits so the frame layout is independent of W.
    assign ext_i = 16'(snap_i_q);
    assign ext_r = 16'(snap_r_q);
    assign ext_j = 16'(snap_j_q);
    assign ext_c = 16'(snap_c_q);

    // Checksum is the 8-bit wrap-around sum of header plus all eight payload bytes.
    assign checksum = HDR
                    + ext_i[15:8] + ext_i[7:0]
                    + ext_r[15:8] + ext_r[7:0]
                    + ext_j[15:8] + ext_j[7:0]
                    + ext_c[15:8] + ext_c[7:0];

    // Select the frame byte addressed by the current index, MSB byte of each counter first.
    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            4'd0:    frame_byte = HDR;
            4'd1:    frame_byte = ext_i[15:8];
            4'd2:    frame_byte = ext_i[7:0];
            4'd3:    frame_byte = ext_r[15:8];
            4'd4:    frame_byte = ext_r[7:0];
            4'd5:    frame_byte = ext_j[15:8];
            4'd6:    frame_byte = ext_j[7:0];
            4'd7:    frame_byte = ext_c[15:8];
            4'd8:    frame_byte = ext_c[7:0];
            4'd9:    frame_byte = checksum;
            default: frame_byte = 8'h00;
        endcase
    end

    // Next-state logic: capture on request in IDLE, advance on each accepted byte in SEND.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        snap_i_d = snap_i_q;
        snap_r_d = snap_r_q;
        snap_j_d = snap_j_q;
        snap_c_d = snap_c_q;
        done_d   = 1'b0;
        drop_d   = drop_q;
        case (state_q)
            S_IDLE: begin
                if (snap_req) begin
                    snap_i_d = i;
                    snap_r_d = r;
                    snap_j_d = j;
                    snap_c_d = cnt_clk;
                    idx_d    = 4'd0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                // A request while a frame is in flight, including the final-byte cycle, is dropped.
                if (snap_req && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (out_ready) begin
                    if (idx_q == 4'd9) begin
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
        endcase
    end

    // State, snapshot and status registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            snap_i_q <= '0;
            snap_r_q <= '0;
            snap_j_q <= '0;
            snap_c_q <= '0;
            done_q   <= 1'b0;
            drop_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            snap_i_q <= snap_i_d;
            snap_r_q <= snap_r_d;
            snap_j_q <= snap_j_d;
            snap_c_q <= snap_c_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign out_valid = (state_q == S_SEND);
    assign busy      = (state_q == S_SEND);
    assign out_data  = (state_q == S_SEND) ? frame_byte : 8'h00;
    assign done      = done_q;
    assign drop_cnt  = drop_q;

endmodule
